// File: rtl/sp_ram_arb.sv
// sp_ram_arb: two-master arbiter in front of a single sp_ram.
// Forwards one request per cycle with zero added latency and routes the
// one-cycle-later RAM response back to the master that owned the access.
// Build option: define SP_RAM_ARB_RR_EN for round-robin tie breaking;
// without it m0 always wins a tie and no priority register exists.
module sp_ram_arb #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m0_req_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  output logic                    m0_gnt_o,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  output logic                    m1_gnt_o,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    ram_req_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  input  logic                    ram_gnt_i,
  input  logic                    ram_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
  output logic                    err_o
);

  logic [1:0] req;
  logic [1:0] gnt;
  logic [1:0] rvalid;
  logic       win;        // 0 selects m0, 1 selects m1
  logic       accept;
  logic       pend_vld_reg, pend_vld_next;
  logic       pend_id_reg, pend_id_next;
  logic       err_reg, err_next;

  assign req    = {m1_req_i, m0_req_i};
  assign accept = ram_req_o & ram_gnt_i;

`ifdef SP_RAM_ARB_RR_EN
  logic prio_reg;         // master that wins the next tie

  // Winner: a lone requester wins, a tie goes to the master named by prio
  always_comb begin
    win = 1'b0;
    if (req == 2'b11)
      win = prio_reg;
    else if (req == 2'b10)
      win = 1'b1;
  end

  // Round-robin pointer: after every accepted access favour the other master
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      prio_reg <= 1'b0;
    else if (accept)
      prio_reg <= ~win;
  end
`else
  // Winner: fixed priority, m1 only when m0 is not requesting
  always_comb begin
    win = 1'b0;
    if (req == 2'b10)
      win = 1'b1;
  end
`endif

  // Request path is a pure mux; idle cycles present m0 fields with req low
  assign ram_req_o   = |req;
  assign ram_addr_o  = win ? m1_addr_i  : m0_addr_i;
  assign ram_we_o    = win ? m1_we_i    : m0_we_i;
  assign ram_wdata_o = win ? m1_wdata_i : m0_wdata_i;
  assign ram_be_o    = win ? m1_be_i    : m0_be_i;

  // Per-master grant and response steering
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      assign gnt[gi]    = ram_gnt_i & req[gi] & (win == 1'(gi));
      assign rvalid[gi] = ram_rvalid_i & pend_vld_reg & (pend_id_reg == 1'(gi));
    end
  endgenerate

  assign m0_gnt_o    = gnt[0];
  assign m1_gnt_o    = gnt[1];
  assign m0_rvalid_o = rvalid[0];
  assign m1_rvalid_o = rvalid[1];
  assign m0_rdata_o  = ram_rdata_i;
  assign m1_rdata_o  = ram_rdata_i;
  assign err_o       = err_reg;

  // Outstanding-access tracking: a response retires the slot, a new
  // acceptance in the same cycle refills it; orphan responses set err
  always_comb begin
    pend_vld_next = pend_vld_reg;
    pend_id_next  = pend_id_reg;
    err_next      = err_reg;
    if (ram_rvalid_i) begin
      pend_vld_next = 1'b0;
      if (!pend_vld_reg)
        err_next = 1'b1;
    end
    if (accept) begin
      pend_vld_next = 1'b1;
      pend_id_next  = win;
    end
  end

  // State register; reset drops any pending response immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld_reg <= 1'b0;
      pend_id_reg  <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      pend_vld_reg <= pend_vld_next;
      pend_id_reg  <= pend_id_next;
      err_reg      <= err_next;
    end
  end

endmodule

// File: tb/tb_sp_ram_arb.sv
// tb_sp_ram_arb: directed and random checks of sp_ram_arb against a
// transaction-level model (pending-response queue plus shadow memory).
module tb_sp_ram_arb;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int BW = DW / 8;

`ifdef SP_RAM_ARB_RR_EN
  localparam logic [5:0] EXP_G0 = 6'b010101;
  localparam logic [5:0] EXP_G1 = 6'b101010;
`else
  localparam logic [5:0] EXP_G0 = 6'b111111;
  localparam logic [5:0] EXP_G1 = 6'b000000;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req_i = 1'b0, m1_req_i = 1'b0;
  logic [AW-1:0] m0_addr_i = '0, m1_addr_i = '0;
  logic          m0_we_i = 1'b0, m1_we_i = 1'b0;
  logic [DW-1:0] m0_wdata_i = '0, m1_wdata_i = '0;
  logic [BW-1:0] m0_be_i = '0, m1_be_i = '0;
  logic          m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic          ram_req_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_wdata_o;
  logic [BW-1:0] ram_be_o;
  logic          ram_gnt_i = 1'b1;
  logic          ram_rvalid_i = 1'b0;
  logic [DW-1:0] ram_rdata_i = '0;
  logic          err_o;

  int total = 0;
  int bad = 0;

  sp_ram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_wdata_i(m0_wdata_i), .m0_be_i(m0_be_i),
    .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_wdata_i(m1_wdata_i), .m1_be_i(m1_be_i),
    .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .ram_req_o(ram_req_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o),
    .ram_wdata_o(ram_wdata_o), .ram_be_o(ram_be_o),
    .ram_gnt_i(ram_gnt_i), .ram_rvalid_i(ram_rvalid_i), .ram_rdata_i(ram_rdata_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input logic [7:0] i);
    return {8'hC0, i, 8'h5A, ~i};
  endfunction

  // ---------------- RAM environment: one-cycle response ----------------
  logic [DW-1:0] ram_mem [0:255];
  logic          mem_init_done = 1'b0;
  logic          force_spur = 1'b1;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(8'(i));
      mem_init_done <= 1'b1;
    end
    ram_rvalid_i <= force_spur;
    if (ram_req_o && ram_gnt_i) begin
      ram_rvalid_i <= 1'b1;
      if (ram_we_o) begin
        for (int b = 0; b < BW; b++)
          if (ram_be_o[b]) ram_mem[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
        ram_rdata_i <= $urandom;
      end else begin
        ram_rdata_i <= ram_mem[ram_addr_o];
      end
    end
  end

  // ---------------- Reference model ----------------
  typedef struct packed {
    logic          id;
    logic          rd;
    logic [DW-1:0] data;
  } pend_t;

  pend_t         pend_q[$];
  logic [DW-1:0] model_mem [0:255];
  logic          err_m = 1'b0;
`ifdef SP_RAM_ARB_RR_EN
  logic          last_win = 1'b1;   // reset state favours m0 on the first tie
`endif

  // Master that should own this cycle's RAM slot (0 also when idle)
  function automatic logic model_winner();
    if (m0_req_i && m1_req_i) begin
`ifdef SP_RAM_ARB_RR_EN
      if (!rst_n) return 1'b0;
      return ~last_win;
`else
      return 1'b0;
`endif
    end
    return (!m0_req_i && m1_req_i);
  endfunction

  initial begin : model
    for (int i = 0; i < 256; i++) model_mem[i] = init_word(8'(i));
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        pend_q.delete();
        err_m = 1'b0;
`ifdef SP_RAM_ARB_RR_EN
        last_win = 1'b1;
`endif
      end else begin
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [BW-1:0] be;
        pend_t         e;
        w = model_winner();
        if (ram_rvalid_i) begin
          if (pend_q.size() == 0) err_m = 1'b1;
          else void'(pend_q.pop_front());
        end
        if ((m0_req_i || m1_req_i) && ram_gnt_i) begin
          a  = w ? m1_addr_i  : m0_addr_i;
          d  = w ? m1_wdata_i : m0_wdata_i;
          be = w ? m1_be_i    : m0_be_i;
          e.id = w;
          if (w ? m1_we_i : m0_we_i) begin
            for (int b = 0; b < BW; b++)
              if (be[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
            e.rd   = 1'b0;
            e.data = '0;
          end else begin
            e.rd   = 1'b1;
            e.data = model_mem[a];
          end
          pend_q.push_back(e);
`ifdef SP_RAM_ARB_RR_EN
          last_win = w;
`endif
          $display("txn t=%0t m%0d %s addr=%02h", $time, w, e.rd ? "rd" : "wr", a);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- Per-cycle compare ----------------
  initial begin : compare
    logic          w, have, own, rd, ev0, ev1;
    logic [DW-1:0] d;
    forever begin
      @(negedge clk);
      w = model_winner();
      chk("ram_req",   64'(ram_req_o),   64'(m0_req_i | m1_req_i));
      chk("ram_addr",  64'(ram_addr_o),  64'(w ? m1_addr_i  : m0_addr_i));
      chk("ram_we",    64'(ram_we_o),    64'(w ? m1_we_i    : m0_we_i));
      chk("ram_wdata", 64'(ram_wdata_o), 64'(w ? m1_wdata_i : m0_wdata_i));
      chk("ram_be",    64'(ram_be_o),    64'(w ? m1_be_i    : m0_be_i));
      chk("m0_gnt",    64'(m0_gnt_o),    64'(ram_gnt_i & m0_req_i & ~w));
      chk("m1_gnt",    64'(m1_gnt_o),    64'(ram_gnt_i & m1_req_i & w));
      have = rst_n && (pend_q.size() != 0);
      own = 1'b0; rd = 1'b0; d = '0;
      if (have) begin
        own = pend_q[0].id;
        rd  = pend_q[0].rd;
        d   = pend_q[0].data;
      end
      ev0 = ram_rvalid_i & have & ~own;
      ev1 = ram_rvalid_i & have & own;
      chk("m0_rvalid", 64'(m0_rvalid_o), 64'(ev0));
      chk("m1_rvalid", 64'(m1_rvalid_o), 64'(ev1));
      chk("m0_rdata_pass", 64'(m0_rdata_o), 64'(ram_rdata_i));
      chk("m1_rdata_pass", 64'(m1_rdata_o), 64'(ram_rdata_i));
      if (ev0 && rd) chk("m0_rdata_sb", 64'(m0_rdata_o), 64'(d));
      if (ev1 && rd) chk("m1_rdata_sb", 64'(m1_rdata_o), 64'(d));
      chk("err", 64'(err_o), 64'(rst_n ? err_m : 1'b0));
    end
  end

  // ---------------- Stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req_i = 1'b0;
    m1_req_i = 1'b0;
  endtask

  task automatic drv(input int m, input logic r, input logic [AW-1:0] a, input logic we,
                     input logic [DW-1:0] d, input logic [BW-1:0] be);
    if (m == 0) begin
      m0_req_i = r; m0_addr_i = a; m0_we_i = we; m0_wdata_i = d; m0_be_i = be;
    end else begin
      m1_req_i = r; m1_addr_i = a; m1_we_i = we; m1_wdata_i = d; m1_be_i = be;
    end
  endtask

  logic [AW-1:0] t4_addr [0:4];
  logic [DW-1:0] t4_data [0:4];
  logic [5:0]    g0v, g1v;
  logic [1:0]    act, took;

  initial begin : main
    t4_addr[0] = 8'h90; t4_addr[1] = 8'h94; t4_addr[2] = 8'h98;
    t4_addr[3] = 8'h9C; t4_addr[4] = 8'hA0;
    t4_data[0] = 32'hC0905A6F; t4_data[1] = 32'hC0945A6B; t4_data[2] = 32'hC0985A67;
    t4_data[3] = 32'hC09C5A63; t4_data[4] = 32'hC0A05A5F;

    // Reset with a stray RAM response present: nothing may leak out
    step();
    @(negedge clk);
    chk("rst_m0_rvalid", 64'(m0_rvalid_o), 64'(0));
    chk("rst_m1_rvalid", 64'(m1_rvalid_o), 64'(0));
    chk("rst_err", 64'(err_o), 64'(0));
    step();
    force_spur = 1'b0;
    step();
    rst_n = 1'b1;

    // T1: m0 reads 0x80 alone
    step();
    drv(0, 1'b1, 8'h80, 1'b0, '0, 4'hF);
    @(negedge clk);
    chk("t1_gnt", 64'(m0_gnt_o), 64'(1));
    step();
    idle();
    @(negedge clk);
    chk("t1_rvalid", 64'(m0_rvalid_o), 64'(1));
    chk("t1_rdata", 64'(m0_rdata_o), 64'(32'hC0805A7F));
    chk("t1_m1_rvalid", 64'(m1_rvalid_o), 64'(0));

    // T2: m0 writes DEADBEEF, then m1 reads it back
    step();
    drv(0, 1'b1, 8'h80, 1'b1, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk("t2_wr_gnt", 64'(m0_gnt_o), 64'(1));
    step();
    m0_req_i = 1'b0;
    drv(1, 1'b1, 8'h80, 1'b0, '0, 4'hF);
    @(negedge clk);
    chk("t2_rd_gnt", 64'(m1_gnt_o), 64'(1));
    step();
    idle();
    @(negedge clk);
    chk("t2_rvalid", 64'(m1_rvalid_o), 64'(1));
    chk("t2_rdata", 64'(m1_rdata_o), 64'(32'hDEADBEEF));

    // T3: six cycles of contention
    step();
    drv(0, 1'b1, 8'h90, 1'b0, '0, 4'hF);
    drv(1, 1'b1, 8'h94, 1'b0, '0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      @(negedge clk);
      g0v[i] = m0_gnt_o;
      g1v[i] = m1_gnt_o;
    end
    chk("t3_m0_gnt_seq", 64'(g0v), 64'(EXP_G0));
    chk("t3_m1_gnt_seq", 64'(g1v), 64'(EXP_G1));
    step();
    idle();

    // T4: m1 streams five reads while m0 is idle
    for (int i = 0; i < 6; i++) begin
      step();
      if (i < 5) drv(1, 1'b1, t4_addr[i], 1'b0, '0, 4'hF);
      else idle();
      @(negedge clk);
      if (i < 5) chk("t4_gnt", 64'(m1_gnt_o), 64'(1));
      if (i > 0) begin
        chk("t4_rvalid", 64'(m1_rvalid_o), 64'(1));
        chk("t4_rdata", 64'(m1_rdata_o), 64'(t4_data[i-1]));
      end
    end

    // Random traffic; a master holds its request until granted
    act = '0;
    took = '0;
    for (int c = 0; c < 800; c++) begin
      step();
      for (int m = 0; m < 2; m++) begin
        if (!act[m] || took[m]) begin
          act[m] = ($urandom_range(0, 3) != 0);
          drv(m, act[m], AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              $urandom, BW'($urandom_range(1, 15)));
        end
      end
      ram_gnt_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = {m1_gnt_o, m0_gnt_o};
    end
    step();
    idle();
    ram_gnt_i = 1'b1;
    step();
    step();

    // T5: reset in the response cycle of an m0 access
    step();
    drv(0, 1'b1, 8'h10, 1'b0, '0, 4'hF);
    @(negedge clk);
    chk("t5_gnt", 64'(m0_gnt_o), 64'(1));
    step();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_m0_rvalid", 64'(m0_rvalid_o), 64'(0));
    chk("t5_m1_rvalid", 64'(m1_rvalid_o), 64'(0));
    step();
    rst_n = 1'b1;
    drv(0, 1'b1, 8'h11, 1'b0, '0, 4'hF);
    drv(1, 1'b1, 8'h12, 1'b0, '0, 4'hF);
    @(negedge clk);
    chk("t5_tie_m0", 64'(m0_gnt_o), 64'(1));
    chk("t5_tie_m1", 64'(m1_gnt_o), 64'(0));
    step();
    idle();
    step();
    step();

    // T6: orphan RAM response
    force_spur = 1'b1;
    step();
    force_spur = 1'b0;
    @(negedge clk);
    chk("t6_m0_rvalid", 64'(m0_rvalid_o), 64'(0));
    chk("t6_m1_rvalid", 64'(m1_rvalid_o), 64'(0));
    chk("t6_err_pre", 64'(err_o), 64'(0));
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      chk("t6_err_sticky", 64'(err_o), 64'(1));
    end
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_err_rst", 64'(err_o), 64'(0));
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("t6_err_after", 64'(err_o), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sp_ram_arb.md
# sp_ram_arb

Two-port arbiter sharing one `sp_ram` instance between two requesters (e.g. core instruction and data ports) on the req/gnt/rvalid protocol. It selects one request per cycle and forwards it to the RAM. It records which master owns each granted access so the RAM response returns to the correct master. Sits directly between the masters and `sp_ram`; adds no latency to the request path.

## Interface
- `ADDR_WIDTH`, 8, word-address width shared with `sp_ram`
- `DATA_WIDTH`, 32, data width; byte enables are `DATA_WIDTH/8` bits
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `m0_req_i`, `m1_req_i`  in  1  master access request
- `m0_addr_i`, `m1_addr_i`  in  ADDR_WIDTH  master address
- `m0_we_i`, `m1_we_i`  in  1  1 = write, 0 = read
- `m0_wdata_i`, `m1_wdata_i`  in  DATA_WIDTH  write data
- `m0_be_i`, `m1_be_i`  in  DATA_WIDTH/8  byte enables
- `m0_gnt_o`, `m1_gnt_o`  out  1  request accepted this cycle
- `m0_rvalid_o`, `m1_rvalid_o`  out  1  response valid (reads and writes)
- `m0_rdata_o`, `m1_rdata_o`  out  DATA_WIDTH  read data
- `ram_req_o`, `ram_addr_o`, `ram_we_o`, `ram_wdata_o`, `ram_be_o`  out  1/ADDR_WIDTH/1/DATA_WIDTH/DATA_WIDTH/8  forwarded request to `sp_ram`
- `ram_gnt_i`  in  1  RAM grant
- `ram_rvalid_i`  in  1  RAM response valid
- `ram_rdata_i`  in  DATA_WIDTH  RAM read data
- `err_o`  out  1  sticky: RAM rvalid arrived with no outstanding access

## Operation
- Per cycle: winner `w` chosen combinationally from active requests.
  - Only one master requesting: that master wins.
  - Both requesting: the master selected by `prio` wins.
- `ram_req_o = m0_req_i | m1_req_i`. `ram_addr/we/wdata/be_o` are muxed from `w`.
- When neither master requests, the mux selects m0 fields; the RAM ignores them because `ram_req_o = 0`.
- `mW_gnt_o = ram_gnt_i & (w == W) & mW_req_i`. The loser sees `gnt = 0` and must hold its request stable.
- Handshake: an access is accepted when `ram_req_o & ram_gnt_i`. On acceptance, register `pend_vld <= 1`, `pend_id <= w`.
- Response: the RAM returns `rvalid` exactly one cycle after acceptance.
  - `mX_rvalid_o = ram_rvalid_i & pend_vld & (pend_id == X)`.
  - `m0_rdata_o` and `m1_rdata_o` are both driven by `ram_rdata_i` (unqualified).
- `pend_vld` clears on `ram_rvalid_i` unless a new acceptance occurs in the same cycle.
  - Back-to-back accesses: the new access is captured and the old response is routed, both in the same cycle.
- `ram_rvalid_i` with `pend_vld = 0`: not forwarded to either master; `err_o <= 1` until reset.
- Priority state `prio` (1 bit, which master wins a tie): on every accepted access, `prio <= ~w`. Idle cycles and ungranted cycles leave `prio` unchanged.

## Timing
- Reset values: `pend_vld = 0`, `pend_id = 0`, `prio = 0` (m0 favoured), `err_o = 0`. Therefore `m0_rvalid_o = m1_rvalid_o = 0` during and after reset.
- `gnt` outputs follow `ram_gnt_i` and requests combinationally; they are 0 whenever the corresponding `req` is 0.
- Request path latency: 0 cycles. Response latency: 1 cycle after grant, same as bare `sp_ram`.
- Throughput: one access per cycle total.
  - Continuous contention alternates m0, m1, m0, …
  - A single continuous requester is granted every cycle.
- `rst_n` asserted mid-access: the pending response is dropped and no `rvalid` reaches either master, even if the RAM still drives `ram_rvalid_i` in that cycle.
- `ram_gnt_i = 0` with requests active: no state changes, and `prio` is held.

## Configuration
- `SP_RAM_ARB_RR_EN` defined: round-robin using `prio` as described above.
- Not defined: fixed priority, m0 always wins ties. The `prio` register is not implemented; m1 is granted only in cycles where `m0_req_i = 0`.

## Test plan
- Reset, then m0 reads addr 0x80 alone → `m0_gnt_o` = 1 in the same cycle; `m0_rvalid_o` = 1 one cycle later with `m0_rdata_o` = RAM[0x80]; `m1_rvalid_o` stays 0.
- m0 writes 0xDEADBEEF to 0x80, then m1 reads 0x80 → `m1_rdata_o` = 0xDEADBEEF one cycle after `m1_gnt_o`.
- Both masters request continuously for 6 cycles (m0 reads 0x90, m1 reads 0x94):
  - With `SP_RAM_ARB_RR_EN`: grants m0, m1, m0, m1, m0, m1, and each `rvalid` goes only to the matching master.
  - Without it: m0 is granted all 6 cycles and `m1_gnt_o` = 0.
- m1 issues back-to-back reads 0x90..0xA0 (5 words) while m0 is idle → 5 consecutive `m1_gnt_o`, followed by 5 consecutive `m1_rvalid_o` lagging by one cycle, with the data in order.
- Assert `rst_n = 0` in the cycle after an m0 grant → `m0_rvalid_o` stays 0 and `prio` returns to 0.
- Force `ram_rvalid_i` = 1 with no outstanding access → both master `rvalid` outputs stay 0 and `err_o` rises and holds 1 until reset.
